// File: rtl/conv_window_gen_if.sv
// Pixel-stream input and 3x3 window output bundle for conv_window_gen.
// The slave side is the window generator; the master side is the producer/consumer.
interface conv_window_gen_if #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) ();
    logic [7:0]                      pixel_in;
    logic                            pixel_valid;
    logic                            pixel_ready;
    logic [7:0]                      pixel_1, pixel_2, pixel_3;
    logic [7:0]                      pixel_4, pixel_5, pixel_6;
    logic [7:0]                      pixel_7, pixel_8, pixel_9;
    logic                            win_valid;
    logic                            win_ack;
    logic [$clog2(IMG_HEIGHT)-1:0]   win_row;
    logic [$clog2(IMG_WIDTH)-1:0]    win_col;
    logic                            frame_done;

    modport slave (
        input  pixel_in, pixel_valid, win_ack,
        output pixel_ready, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, win_valid, win_row,
               win_col, frame_done
    );

    modport master (
        output pixel_in, pixel_valid, win_ack,
        input  pixel_ready, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5,
               pixel_6, pixel_7, pixel_8, pixel_9, win_valid, win_row,
               win_col, frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting 3x3 register,
// each interior window held until the consumer acks it.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic             clk,
    input  logic             reset,
    conv_window_gen_if.slave bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       win_q [3][3];
    logic [7:0]       win_d [3][3];
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] wcol_q, wcol_d;
    logic             done_q, done_d;

    logic [7:0] lb_top [IMG_WIDTH];
    logic [7:0] lb_mid [IMG_WIDTH];

    logic xfer, last_col, last_row, win_pos, last_win;

    assign xfer     = bus.pixel_valid && bus.pixel_ready;
    assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign win_pos  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_win = (wrow_q == ROW_W'(IMG_HEIGHT - 2)) && (wcol_q == COL_W'(IMG_WIDTH - 2));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        done_d  = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (xfer) begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        win_d[r][0] = win_q[r][1];
                        win_d[r][1] = win_q[r][2];
                    end
                    // Right column uses buffer contents before this pixel's write.
                    win_d[0][2] = lb_top[col_q];
                    win_d[1][2] = lb_mid[col_q];
                    win_d[2][2] = bus.pixel_in;
                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (win_pos) begin
                        state_d = ST_HOLD;
                        wrow_d  = row_q - ROW_W'(1);
                        wcol_d  = col_q - COL_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.win_ack) begin
                    state_d = ST_ACCEPT;
                    done_d  = last_win;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCEPT;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            wrow_q  <= '0;
            wcol_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            done_q  <= done_d;
        end
    end

    // Line buffers are never cleared; row gating keeps stale entries unobservable.
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb_top[col_q] <= lb_mid[col_q];
            lb_mid[col_q] <= bus.pixel_in;
        end
    end

    assign bus.pixel_ready = !reset && (state_q == ST_ACCEPT);
    assign bus.win_valid   = (state_q == ST_HOLD);
    assign bus.frame_done  = done_q;
    assign bus.win_row     = wrow_q;
    assign bus.win_col     = wcol_q;
    assign bus.pixel_1     = win_q[0][0];
    assign bus.pixel_2     = win_q[0][1];
    assign bus.pixel_3     = win_q[0][2];
    assign bus.pixel_4     = win_q[1][0];
    assign bus.pixel_5     = win_q[1][1];
    assign bus.pixel_6     = win_q[1][2];
    assign bus.pixel_7     = win_q[2][0];
    assign bus.pixel_8     = win_q[2][1];
    assign bus.pixel_9     = win_q[2][2];
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 frame with a window scoreboard.
module tb_conv_window_gen;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
    conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int win_cnt, fd_cnt;
    logic [127:0] sb [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dut_win();
        logic [127:0] v;
        v = '0;
        v = {bus.pixel_1, bus.pixel_2, bus.pixel_3, bus.pixel_4, bus.pixel_5,
             bus.pixel_6, bus.pixel_7, bus.pixel_8, bus.pixel_9, bus.win_row, bus.win_col};
        return v;
    endfunction

    // (r,c) is the pixel whose transfer completes the window.
    function automatic logic [127:0] exp_win(input int base, input int r, input int c);
        logic [127:0] v;
        logic [7:0]   p;
        logic [RW-1:0] wr;
        logic [CW-1:0] wc;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                p = 8'(base + 10 * (r - 2 + i) + (c - 2 + j));
                v = (v << 8) | 128'(p);
            end
        wr = RW'(r - 1);
        wc = CW'(c - 1);
        v = (v << RW) | 128'(wr);
        v = (v << CW) | 128'(wc);
        return v;
    endfunction

    task automatic send_frame(input int base, input bit gaps, input int ack_delay,
                              input bit spur, input int abort_at);
        logic [127:0] got, exp;
        int idle;
        win_cnt = 0;
        fd_cnt  = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                idle = gaps ? int'($urandom_range(0, 2)) : 0;
                repeat (idle) begin
                    bus.pixel_valid = 1'b0;
                    bus.pixel_in    = 8'($urandom);
                    bus.win_ack     = spur;
                    tick();
                    check("idle_win_valid", bus.win_valid, 0);
                end
                bus.pixel_valid = 1'b1;
                bus.pixel_in    = 8'(base + 10 * r + c);
                bus.win_ack     = spur;
                check("pixel_ready", bus.pixel_ready, 1);
                tick();
                bus.pixel_valid = 1'b0;
                bus.win_ack     = 1'b0;
                check("frame_done_idle", bus.frame_done, 0);
                if (r >= 2 && c >= 2) sb.push_back(exp_win(base, r, c));
                check("win_valid_latency", bus.win_valid, (r >= 2 && c >= 2));
                if (bus.win_valid && sb.size() > 0) begin
                    exp = sb.pop_front();
                    got = dut_win();
                    check("window", got, exp);
                    win_cnt++;
                    if (r * W + c == abort_at) begin
                        reset = 1'b1;
                        #1;
                        check("ready_in_reset", bus.pixel_ready, 0);
                        tick();
                        reset = 1'b0;
                        #1;
                        check("reset_win_valid", bus.win_valid, 0);
                        check("reset_frame_done", bus.frame_done, 0);
                        check("reset_ready", bus.pixel_ready, 1);
                        sb.delete();
                        return;
                    end
                    bus.pixel_valid = 1'b1;
                    bus.pixel_in    = 8'hEE;
                    repeat (ack_delay) begin
                        tick();
                        check("hold_ready", bus.pixel_ready, 0);
                        check("hold_valid", bus.win_valid, 1);
                        check("hold_stable", dut_win(), exp);
                    end
                    bus.win_ack = 1'b1;
                    tick();
                    bus.win_ack     = 1'b0;
                    bus.pixel_valid = 1'b0;
                    check("ack_release", {bus.win_valid, bus.pixel_ready}, 2'b01);
                    if (bus.frame_done) fd_cnt++;
                    check("frame_done", bus.frame_done, (r == H - 1 && c == W - 1));
                end
            end
        end
        check("win_count", win_cnt, (W - 2) * (H - 2));
        check("frame_done_count", fd_cnt, 1);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        bus.win_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ready_during_reset", bus.pixel_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", bus.pixel_ready, 1);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_window", dut_win(), 0);

        send_frame(0, 1'b0, 0, 1'b0, -1);    // basic
        send_frame(0, 1'b0, 5, 1'b0, -1);    // backpressure
        send_frame(0, 1'b1, 0, 1'b0, -1);    // input gaps
        send_frame(0, 1'b0, 0, 1'b0, -1);    // frame wrap, back to back
        send_frame(100, 1'b0, 0, 1'b0, -1);
        send_frame(0, 1'b0, 0, 1'b0, 13);    // reset while holding window (1,2)
        send_frame(0, 1'b0, 0, 1'b0, -1);
        send_frame(0, 1'b1, 1, 1'b1, -1);    // spurious ack during ACCEPT

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
